// File: rtl/rnd_sequencer.sv
// Seeds, clocks and arbitrates the hash generator's 8-bit LFSR between two
// requesters; the shift register itself lives outside and is driven via sr_*.
module rnd_sequencer #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
   parameter int               SHIFTS   = 8,
   parameter logic [WIDTH-1:0] SEED_DEF = 8'h01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req0,
   input  logic             req1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] rnd_data,
   output logic             seeded,
   output logic             busy,
   output logic [WIDTH-1:0] sr_seed,
   output logic             sr_init,
   output logic             sr_en,
   output logic             sr_fb,
   input  logic [WIDTH-1:0] sr_out,
   output logic [2:0]       fsm_state
);

   // Handshake: reqN is held high until ackN; ackN is a one-cycle pulse and
   // rnd_data is valid in that cycle. A granted word always completes.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_READY   = 3'd2,
      S_SHIFT   = 3'd3,
      S_DELIVER = 3'd4
   } state_t;

   localparam int             CW       = $clog2(SHIFTS + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(SHIFTS - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] seed_reg;
   logic             pending;
   logic             last;
   logic             gnt;
   logic             pick;

   assign sr_fb = ^(sr_out & TAPS);

   // Tie goes to the requester not served last; a lone requester always wins.
   assign pick = (req0 && req1) ? ~last : req1;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_READY;
         S_READY: begin
            if (start || pending)  state_nxt = S_LOAD;
            else if (req0 || req1) state_nxt = S_SHIFT;
         end
         S_SHIFT:   if (cnt == LAST_CNT) state_nxt = S_DELIVER;
         S_DELIVER: state_nxt = S_READY;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sr_init   = (state == S_LOAD);
      sr_en     = (state == S_SHIFT);
      busy      = (state == S_LOAD) || (state == S_SHIFT) || (state == S_DELIVER);
      ack0      = (state == S_DELIVER) && !gnt;
      ack1      = (state == S_DELIVER) && gnt;
      sr_seed   = seed_reg;
      fsm_state = state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         seed_reg <= '0;
         pending  <= 1'b0;
         last     <= 1'b1;
         gnt      <= 1'b0;
         seeded   <= 1'b0;
         rnd_data <= '0;
      end else begin
         // Zero would lock the LFSR, so it is swapped for SEED_DEF on capture.
         if (start) seed_reg <= (seed_in == '0) ? SEED_DEF : seed_in;

         if (start && busy)          pending <= 1'b1;
         else if (state == S_READY)  pending <= 1'b0;

         if (state == S_LOAD) seeded <= 1'b1;

         if (state == S_SHIFT) cnt <= cnt + 1'b1;
         else                  cnt <= '0;

         if (state == S_READY && state_nxt == S_SHIFT) begin
            gnt  <= pick;
            last <= pick;
         end

         // The register takes its final shift on this same edge, so capture
         // the value it is about to hold rather than its current contents.
         if (state == S_SHIFT && state_nxt == S_DELIVER)
            rnd_data <= {sr_out[WIDTH-2:0], sr_fb};
      end
   end

endmodule
